// File: rtl/count_mon_pkg.sv
// Shared encodings and default widths for the count sequence monitor.
package count_mon_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_TRACK = 2'b01,
    ST_ERROR = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    CLS_HOLD = 2'b00,
    CLS_STEP = 2'b01,
    CLS_WRAP = 2'b10,
    CLS_BAD  = 2'b11
  } cls_t;

endpackage

// File: rtl/seq_classify.sv
// Combinational classifier: relation of the new count value to the previous one.
module seq_classify
  import count_mon_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] q_d,
  output cls_t             cls
);

  logic at_top;

  assign at_top = (q_d == '1);

  always_comb begin
    cls = CLS_BAD;
    if (q == q_d)                           cls = CLS_HOLD;
    else if (!at_top && q == q_d + 1'b1)    cls = CLS_STEP;
    else if (at_top && q == '0)             cls = CLS_WRAP;
  end

endmodule

// File: rtl/count_seq_monitor.sv
// Watches an upstream counter's value sequence: counts wraps, flags matches,
// and latches a sticky error on any illegal transition.
module count_seq_monitor
  import count_mon_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] match_val,
  input  logic             clr,
  output logic [CNT_W-1:0] wrap_cnt,
  output logic             wrap_pulse,
  output logic             match_pulse,
  output logic             err,
  output logic [1:0]       state
);

  state_t           st, st_nxt;
  cls_t             cls;
  logic [WIDTH-1:0] q_d;
  logic [CNT_W-1:0] cnt_nxt;
  logic             wrap_nxt, match_nxt, err_nxt;

  seq_classify #(.WIDTH(WIDTH)) u_classify (
    .q   (q),
    .q_d (q_d),
    .cls (cls)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st          <= ST_IDLE;
      q_d         <= '0;
      wrap_cnt    <= '0;
      wrap_pulse  <= 1'b0;
      match_pulse <= 1'b0;
      err         <= 1'b0;
    end else begin
      st          <= st_nxt;
      q_d         <= q;
      wrap_cnt    <= cnt_nxt;
      wrap_pulse  <= wrap_nxt;
      match_pulse <= match_nxt;
      err         <= err_nxt;
    end
  end

  // The unused 2'b11 encoding falls into default and behaves like IDLE.
  always_comb begin
    st_nxt = ST_IDLE;
    case (st)
      ST_TRACK: st_nxt = (cls == CLS_BAD) ? ST_ERROR : ST_TRACK;
      ST_ERROR: st_nxt = clr ? ST_IDLE : ST_ERROR;
      default:  st_nxt = ST_TRACK;
    endcase
  end

  always_comb begin
    wrap_nxt  = 1'b0;
    match_nxt = 1'b0;
    err_nxt   = err;
    cnt_nxt   = wrap_cnt;
    case (st)
      ST_TRACK: begin
        if (cls == CLS_WRAP) begin
          wrap_nxt = 1'b1;
          if (wrap_cnt != '1) cnt_nxt = wrap_cnt + 1'b1;
        end
        match_nxt = (cls == CLS_STEP || cls == CLS_WRAP) && (q == match_val);
        if (cls == CLS_BAD) err_nxt = 1'b1;
        // clr overrides a coincident wrap increment; the pulse still fires
        if (clr) cnt_nxt = '0;
      end
      ST_ERROR: begin
        if (clr) begin
          err_nxt = 1'b0;
          cnt_nxt = '0;
        end
      end
      default: cnt_nxt = '0;
    endcase
  end

  assign state = st;

endmodule
